// File: rtl/button_pkg.sv
// Shared definitions for the push-button conditioner.
//
// Contents:
//   btn_state_e             debounce FSM state encoding (2 bits)
//   DEFAULT_DEBOUNCE_TICKS  default number of stable tick samples to accept an edge
//   DEFAULT_LONG_TICKS      default number of ticks held before a long-press pulse
//   cnt_width()             width of the shared debounce / long-press counter
package button_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  localparam int DEFAULT_DEBOUNCE_TICKS = 10;
  localparam int DEFAULT_LONG_TICKS     = 1000;

  // The counter must hold its largest target value without wrapping. When the
  // long-press feature is not built, only the debounce target matters.
  function automatic int cnt_width(input int debounce_ticks,
                                   input int long_ticks,
                                   input bit long_en);
    int top;
    top = debounce_ticks;
    if (long_en && (long_ticks > top)) top = long_ticks;
    if (top < 1) top = 1;
    return $clog2(top + 1);
  endfunction

endpackage

// File: rtl/button_conditioner_sync_chain.sv
// Multi-flop synchroniser for an asynchronous board input.
//
// Ports:
//   clk  input   sampling clock
//   ar   input   asynchronous active-low clear; all stages load RESET_VAL
//   d    input   asynchronous input
//   q    output  synchronised output (last stage)
//
// STAGES below 2 is raised to 2; a single flop is not a synchroniser.
module sync_chain #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic ar,
  input  logic d,
  output logic q
);

  localparam int N = (STAGES < 2) ? 2 : STAGES;

  logic [N-1:0] stage;

  always_ff @(posedge clk or negedge ar) begin
    if (!ar) begin
      stage <= {N{RESET_VAL}};
    end else begin
      stage <= {stage[N-2:0], d};
    end
  end

  assign q = stage[N-1];

endmodule

// File: rtl/button_conditioner.sv
// Push-button conditioner: synchronises a raw key pin, debounces it against a
// tick enable and produces a clean level plus single-cycle press / release
// pulses. Optional long-press pulse when BUTTON_LONG_PRESS_EN is defined.
//
// Ports:
//   clk            input   block clock, rising edge
//   ar             input   asynchronous active-low reset
//   tick           input   debounce sample enable (one clk wide, or tie high)
//   btn_raw        input   asynchronous key pin
//   btn_level      output  debounced active-high pressed level
//   press_pulse    output  one clk high on an accepted press
//   release_pulse  output  one clk high on an accepted release
//   long_press     output  one clk high after LONG_TICKS in PRESSED
//                          (constant 0 unless BUTTON_LONG_PRESS_EN is defined)
//
// state        | meaning
// -------------+--------------------------------------------------------------
// IDLE         | key released and accepted as released
// PRESS_WAIT   | key seen pressed, counting stable ticks before accepting
// PRESSED      | press accepted; counts ticks for long-press when built
// RELEASE_WAIT | key seen released, counting stable ticks before accepting
module button_conditioner
  import button_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int DEBOUNCE_TICKS = DEFAULT_DEBOUNCE_TICKS,
  parameter bit ACTIVE_LOW_IN  = 1'b1,
  parameter int LONG_TICKS     = DEFAULT_LONG_TICKS
) (
  input  logic clk,
  input  logic ar,
  input  logic tick,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press
);

`ifdef BUTTON_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  localparam int            CW      = cnt_width(DEBOUNCE_TICKS, LONG_TICKS, LONG_EN);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_TICKS - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

`ifdef BUTTON_LONG_PRESS_EN
  localparam logic [CW-1:0] LONG_MAX  = CW'(LONG_TICKS);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_TICKS - 1);
`endif

  logic          s_in;
  logic          sync;
  btn_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pressed_half;

  // Polarity is corrected before the synchroniser so its reset value of 0
  // always means "not pressed".
  assign s_in = btn_raw ^ ACTIVE_LOW_IN;

  sync_chain #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b0)
  ) u_sync (
    .clk (clk),
    .ar  (ar),
    .d   (s_in),
    .q   (sync)
  );

`ifdef BUTTON_LONG_PRESS_EN
  logic long_evt;
  logic long_evt_q;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef BUTTON_LONG_PRESS_EN
    long_evt = 1'b0;
`endif
    if (tick) begin
      unique case (state_q)
        IDLE: begin
          if (sync) begin
            if (DEBOUNCE_TICKS == 1) begin
              state_d = PRESSED;
              cnt_d   = '0;
            end else begin
              state_d = PRESS_WAIT;
              cnt_d   = CNT_ONE;
            end
          end else begin
            cnt_d = '0;
          end
        end

        PRESS_WAIT: begin
          if (!sync) begin
            // Any bounce restarts the count from scratch.
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == DB_LAST) begin
            state_d = PRESSED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        PRESSED: begin
          if (!sync) begin
            if (DEBOUNCE_TICKS == 1) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              state_d = RELEASE_WAIT;
              cnt_d   = CNT_ONE;
            end
          end
`ifdef BUTTON_LONG_PRESS_EN
          else if (cnt_q < LONG_MAX) begin
            cnt_d    = cnt_q + CNT_ONE;
            long_evt = (cnt_q == LONG_LAST);
          end
`endif
        end

        RELEASE_WAIT: begin
          if (sync) begin
            // The count was reused for the release debounce; parking it at
            // the long-press target keeps long_press from firing twice.
            state_d = PRESSED;
`ifdef BUTTON_LONG_PRESS_EN
            cnt_d   = LONG_MAX;
`else
            cnt_d   = '0;
`endif
          end else if (cnt_q == DB_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign pressed_half = (state_q == PRESSED) || (state_q == RELEASE_WAIT);

  // Outputs trail the state by one clk. Edges are found by comparing the state
  // against the registered level, so a pulse lasts exactly one clk whatever
  // tick does, and press / release can never coincide.
  always_ff @(posedge clk or negedge ar) begin
    if (!ar) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      btn_level     <= pressed_half;
      press_pulse   <= (state_q == PRESSED) && !btn_level;
      release_pulse <= (state_q == IDLE) && btn_level;
    end
  end

`ifdef BUTTON_LONG_PRESS_EN
  // Extra stage keeps long_press aligned with press_pulse timing: it lands
  // LONG_TICKS clk after press_pulse when tick is held high.
  always_ff @(posedge clk or negedge ar) begin
    if (!ar) begin
      long_evt_q <= 1'b0;
      long_press <= 1'b0;
    end else begin
      long_evt_q <= long_evt;
      long_press <= long_evt_q;
    end
  end
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

  logic clk;
  logic ar;
  logic tick;
  logic btn_raw;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic long_press;

  int checks = 0;
  int failures = 0;

  int cyc_n = 0;
  int tick_period = 1;
  bit tick_off = 1'b0;

  int press_cnt, release_cnt, long_cnt;
  int last_press, last_release, last_long;
  int lvl0_cnt;
  int press_wide = 0, release_wide = 0, long_wide = 0;
  bit prev_p = 1'b0, prev_r = 1'b0, prev_l = 1'b0;

  int exp_long_cnt;
  int exp_last_long;

  button_conditioner #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_TICKS (10),
    .ACTIVE_LOW_IN  (1'b1),
    .LONG_TICKS     (20)
  ) dut (
    .clk           (clk),
    .ar            (ar),
    .tick          (tick),
    .btn_raw       (btn_raw),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_press    (long_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start();
    cyc_n        = 0;
    press_cnt    = 0;
    release_cnt  = 0;
    long_cnt     = 0;
    last_press   = 0;
    last_release = 0;
    last_long    = 0;
    lvl0_cnt     = 0;
  endtask

  // Advances n clocks; tick for edge k is high when k is a multiple of the
  // period. Samples 1 time unit after each rising edge.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      tick = tick_off ? 1'b0 : (((cyc_n + 1) % tick_period) == 0);
      @(posedge clk);
      #1;
      cyc_n++;
      if (press_pulse === 1'b1) begin
        press_cnt++; last_press = cyc_n;
        if (prev_p) press_wide++;
      end
      if (release_pulse === 1'b1) begin
        release_cnt++; last_release = cyc_n;
        if (prev_r) release_wide++;
      end
      if (long_press === 1'b1) begin
        long_cnt++; last_long = cyc_n;
        if (prev_l) long_wide++;
      end
      if (btn_level !== 1'b1) lvl0_cnt++;
      prev_p = (press_pulse === 1'b1);
      prev_r = (release_pulse === 1'b1);
      prev_l = (long_press === 1'b1);
    end
  endtask

  initial begin
`ifdef BUTTON_LONG_PRESS_EN
    exp_long_cnt  = 1;
    exp_last_long = 33;
`else
    exp_long_cnt  = 0;
    exp_last_long = 0;
`endif
    ar      = 1'b0;
    btn_raw = 1'b1;
    tick    = 1'b1;
    start();

    // Reset, then idle with key released
    repeat (3) @(posedge clk);
    #1;
    check("rst_level", btn_level, 0);
    check("rst_press", press_pulse, 0);
    check("rst_release", release_pulse, 0);
    check("rst_long", long_press, 0);
    ar = 1'b1;
    start();
    run(50);
    check("idle_press_cnt", press_cnt, 0);
    check("idle_release_cnt", release_cnt, 0);
    check("idle_level_low", lvl0_cnt, 50);
    check("idle_long_cnt", long_cnt, 0);

    // Bounce rejection: 3-cycle pressed windows never reach 10 ticks
    start();
    for (int k = 0; k < 10; k++) begin
      btn_raw = (k % 2 == 0) ? 1'b0 : 1'b1;
      run(3);
    end
    btn_raw = 1'b1;
    run(30);
    check("bounce_press_cnt", press_cnt, 0);
    check("bounce_level_low", lvl0_cnt, 60);

    // Clean press: 2 sync + 10 ticks + 1 = cycle 13 (also proves IDLE, cnt cleared)
    start();
    btn_raw = 1'b0;
    run(12);
    check("press_c12_pulse", press_pulse, 0);
    check("press_c12_level", btn_level, 0);
    run(1);
    check("press_c13_pulse", press_pulse, 1);
    check("press_c13_level", btn_level, 1);
    run(1);
    check("press_c14_pulse", press_pulse, 0);
    run(6);
    check("press_cnt", press_cnt, 1);
    check("press_cycle", last_press, 13);

    // Release bounce: 4 ticks released, then pressed again
    start();
    btn_raw = 1'b1;
    run(4);
    btn_raw = 1'b0;
    run(30);
    check("rbounce_release_cnt", release_cnt, 0);
    check("rbounce_press_cnt", press_cnt, 0);
    check("rbounce_level_held", lvl0_cnt, 0);

    // Clean release
    start();
    btn_raw = 1'b1;
    run(12);
    check("rel_c12_pulse", release_pulse, 0);
    check("rel_c12_level", btn_level, 1);
    run(1);
    check("rel_c13_pulse", release_pulse, 1);
    check("rel_c13_level", btn_level, 0);
    run(7);
    check("rel_cnt", release_cnt, 1);
    check("rel_cycle", last_release, 13);
    check("rel_press_cnt", press_cnt, 0);

    // Long hold: long_press 20 clk after press_pulse when built
    start();
    btn_raw = 1'b0;
    run(60);
    check("long_press_cnt", press_cnt, 1);
    check("long_press_cycle", last_press, 13);
    check("long_cnt", long_cnt, exp_long_cnt);
    check("long_cycle", last_long, exp_last_long);
    btn_raw = 1'b1;
    run(20);
    check("long_rel_cnt", release_cnt, 1);
    check("long_cnt_after", long_cnt, exp_long_cnt);

    // Tick every 50th clk: ticks at 50..500, PRESSED at 500, pulse at 501
    start();
    tick_period = 50;
    btn_raw = 1'b0;
    run(500);
    check("gate_press_cnt_500", press_cnt, 0);
    check("gate_level_500", btn_level, 0);
    run(1);
    check("gate_pulse_501", press_pulse, 1);
    check("gate_level_501", btn_level, 1);
    run(1);
    check("gate_pulse_502", press_pulse, 0);
    check("gate_press_cnt", press_cnt, 1);

    // Reset while pressed: level drops before any clock edge
    #3;
    ar = 1'b0;
    #1;
    check("midrst_level", btn_level, 0);
    check("midrst_press", press_pulse, 0);
    tick_period = 1;
    run(2);
    ar = 1'b1;
    start();
    run(12);
    check("repress_c12_pulse", press_pulse, 0);
    run(1);
    check("repress_c13_pulse", press_pulse, 1);
    check("repress_cycle", last_press, 13);
    run(2);

    // tick held low: release is not accepted, state and level hold
    start();
    tick_off = 1'b1;
    btn_raw = 1'b1;
    run(100);
    check("hold_release_cnt", release_cnt, 0);
    check("hold_level", lvl0_cnt, 0);
    tick_off = 1'b0;
    start();
    run(10);
    check("hold_c10_release", release_pulse, 0);
    run(1);
    check("hold_c11_release", release_pulse, 1);
    check("hold_c11_level", btn_level, 0);
    run(5);
    check("hold_release_total", release_cnt, 1);

    check("press_width", press_wide, 0);
    check("release_width", release_wide, 0);
    check("long_width", long_wide, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Producer end of the push-button interface that feeds the stop input of ctr_fsm.
- Synchronises a raw, bouncy, optionally active-low key into clk.
- Debounces it against a slow tick enable and emits a clean level plus single-cycle press and release pulses.
- Sits between the board key pin and the reaction-timer FSM, clocked by the fast (1 kHz) clock domain or by the system clock with a tick enable.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the input synchroniser chain (minimum 2).
- DEBOUNCE_TICKS, 10, consecutive tick samples the synchronised input must hold a new value before it is accepted (minimum 1).
- ACTIVE_LOW_IN, 1, when 1 the raw input is inverted before synchronisation (board keys read 0 when pressed).
- LONG_TICKS, 1000, ticks in PRESSED before a long-press pulse (used only with LONG_PRESS_EN).

Ports:
- clk  input  1  block clock; all state on the rising edge.
- ar  input  1  asynchronous, active-low reset; everything clears immediately while ar=0.
- tick  input  1  sample enable, one clk cycle wide; tie to 1 to debounce in clk cycles.
- btn_raw  input  1  asynchronous key pin.
- btn_level  output  1  debounced, active-high pressed level.
- press_pulse  output  1  one clk cycle high on an accepted press.
- release_pulse  output  1  one clk cycle high on an accepted release.
- long_press  output  1  one clk cycle high when a press has lasted LONG_TICKS; constant 0 without LONG_PRESS_EN.

Behaviour:
- Reset (ar=0):
  - Synchroniser flops and debounce counter clear to 0.
  - State goes to IDLE.
  - All outputs are 0.
  - Synchroniser flops clear to the "not pressed" value after polarity correction.
- Polarity: s_in = btn_raw XOR ACTIVE_LOW_IN, then passed through SYNC_STAGES flops. sync = last stage. Latency from pin to sync is SYNC_STAGES clk edges.
- Debounce counter width: clog2(max(DEBOUNCE_TICKS, LONG_TICKS)+1). The counter never wraps and saturates at its target.
- FSM has 4 states, and transitions are evaluated only on cycles with tick=1:
  - IDLE: if sync=1, cnt<=1, go to PRESS_WAIT (if DEBOUNCE_TICKS=1, go directly to PRESSED instead). Otherwise cnt<=0.
  - PRESS_WAIT: if sync=0, return to IDLE with cnt<=0 (a bounce restarts the count). If sync=1 and cnt+1=DEBOUNCE_TICKS, go to PRESSED, cnt<=0. Otherwise cnt++.
  - PRESSED: if sync=0, cnt<=1, go to RELEASE_WAIT (if DEBOUNCE_TICKS=1, go to IDLE). Otherwise, with LONG_PRESS_EN, cnt increments saturating at LONG_TICKS.
  - RELEASE_WAIT: if sync=1, return to PRESSED and restore cnt to LONG_TICKS (so long_press cannot fire twice). If sync=0 and cnt+1=DEBOUNCE_TICKS, go to IDLE, cnt<=0. Otherwise cnt++.
- btn_level is registered: 1 in PRESSED and RELEASE_WAIT, 0 in IDLE and PRESS_WAIT.
- press_pulse is registered and asserts the clk cycle after the edge that entered PRESSED from PRESS_WAIT or IDLE. It is never asserted on a RELEASE_WAIT→PRESSED return.
- release_pulse is registered and asserts the cycle after entering IDLE from RELEASE_WAIT or PRESSED.
- Total accept latency from a stable pin change is SYNC_STAGES clk + DEBOUNCE_TICKS ticks + 1 clk.
- Pulses are exactly one clk wide, even when tick is held at 1.
- Press and release pulses can never assert in the same cycle. A minimum of one tick separates them.
- With tick=0 permanently, state and outputs hold. The synchroniser still shifts.
- If reset is asserted mid-press, outputs drop to 0 asynchronously. After release of reset, a still-held key is re-debounced from IDLE and produces a fresh press_pulse.

Optional Feature:
- Macro BUTTON_LONG_PRESS_EN.
- Defined: in PRESSED, cnt counts ticks. On the tick where cnt reaches LONG_TICKS, long_press pulses for one clk, the cycle after that edge. It fires at most once per press.
- Undefined: no long-press logic is built, long_press is driven constant 0, and the counter is sized for DEBOUNCE_TICKS only.

Decomposition:
- Shared package button_pkg holds:
  - the state typedef (IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT, 2-bit encoding),
  - the default DEBOUNCE_TICKS and LONG_TICKS constants,
  - a counter-width function.
- One natural sub-module: sync_chain, a parameterised SYNC_STAGES flop chain with async active-low clear and a reset value, reusable for any asynchronous board input such as the ar pin.

Test Plan:
- Reset and idle: ar=0, btn_raw=1 (ACTIVE_LOW_IN=1, not pressed), release ar, tick=1 → all outputs 0 for 50 cycles.
- Clean press, tick=1, DEBOUNCE_TICKS=10: btn_raw 1→0 at cycle 0 → press_pulse high exactly at cycle 2+10+1=13 for one cycle, btn_level=1 from cycle 13.
- Bounce rejection: btn_raw toggles 0/1 every 3 cycles for 30 cycles, then held 1 → no press_pulse, btn_level stays 0, state returns to IDLE.
- Release bounce: in PRESSED, btn_raw goes 1 for 4 ticks then 0 again → no release_pulse, no second press_pulse, btn_level stays 1. A subsequent stable 1 for 10 ticks gives one release_pulse.
- Tick gating: tick every 50th cycle, held press → press_pulse after 10 ticks (≈500 cycles) and is one clk wide. Reset asserted while pressed clears btn_level within the same cycle.
- BUTTON_LONG_PRESS_EN, LONG_TICKS=20, tick=1: hold pressed 40 ticks → one long_press 20 ticks after press_pulse, none afterward. Without the macro, long_press is 0 throughout.
